// File: rtl/dac_output_stage_pkg.sv
// dac_output_stage shared constants, config field offsets and envelope states.
// PEAK_MONITOR_EN (top) enables the peak/saturation monitor.
package dac_output_stage_pkg;

  localparam int AXIS_W = 16;
  localparam int DAC_W  = 14;
  localparam int CFG_W  = 64;
  localparam int ENV_W  = 17;

  localparam logic [ENV_W-1:0] ENV_ONE = 17'h10000;

  localparam int CFG_AMP_LSB  = 0;
  localparam int CFG_OFF_LSB  = 16;
  localparam int CFG_STEP_LSB = 32;

  localparam int DAC_MAX = 8191;
  localparam int DAC_MIN = -8192;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } ramp_state_e;

endpackage

// File: rtl/dac_output_stage_if.sv
// Sample stream from signal_generator into dac_output_stage.
// Master drives data/valid; slave returns ready.
interface dac_output_stage_if #(
  parameter int W = 16
);
  logic [W-1:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready
  );
endinterface

// File: rtl/dac_ramp_envelope.sv
// Ramp envelope FSM: env register, latched ramp step, ramp_done pulse.
// Env moves only on accepted samples; direction changes are evaluated every cycle.
module dac_ramp_envelope
  import dac_output_stage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             accept,
  input  logic [15:0]      cfg_step,
  output logic [ENV_W-1:0] env,
  output ramp_state_e      state,
  output logic             ramp_done
);

  ramp_state_e      state_q, state_d;
  logic [ENV_W-1:0] env_q, env_d;
  logic [15:0]      step_q, step_d;
  logic             done_q, done_d;
  logic [ENV_W:0]   up_sum;
  logic [ENV_W-1:0] step_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      env_q   <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  // A direction change takes the cycle; no env step and no done pulse.
  always_comb begin
    state_d  = state_q;
    env_d    = env_q;
    step_d   = step_q;
    done_d   = 1'b0;
    step_ext = {1'b0, step_q};
    up_sum   = {1'b0, env_q} + {2'b00, step_q};
    unique case (state_q)
      ST_IDLE: begin
        env_d = '0;
        if (enable) begin
          state_d = ST_RAMP_UP;
          step_d  = cfg_step;
        end
      end
      ST_RAMP_UP: begin
        if (!enable) begin
          state_d = ST_RAMP_DOWN;
          step_d  = cfg_step;
        end else if (accept) begin
          if (step_q == '0 || up_sum >= {1'b0, ENV_ONE}) begin
            env_d   = ENV_ONE;
            state_d = ST_HOLD;
            done_d  = 1'b1;
          end else begin
            env_d = up_sum[ENV_W-1:0];
          end
        end
      end
      ST_HOLD: begin
        env_d = ENV_ONE;
        if (!enable) begin
          state_d = ST_RAMP_DOWN;
          step_d  = cfg_step;
        end
      end
      ST_RAMP_DOWN: begin
        if (enable) begin
          state_d = ST_RAMP_UP;
          step_d  = cfg_step;
        end else if (accept) begin
          if (step_q == '0 || env_q <= step_ext) begin
            env_d   = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            env_d = env_q - step_ext;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign env       = env_q;
  assign state     = state_q;
  assign ramp_done = done_q;

endmodule

// File: rtl/dac_output_stage.sv
// dac_output_stage: amplitude scale, envelope, DC offset, saturate to DAC word.
// Define PEAK_MONITOR_EN to build the peak/saturation monitor.
module dac_output_stage
  import dac_output_stage_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = AXIS_W,
  parameter int DAC_WIDTH        = DAC_W,
  parameter int CFG_DATA_WIDTH   = CFG_W
) (
  input  logic                      clk,
  input  logic                      reset,
  dac_output_stage_if.slave         s_axis,
  input  logic [CFG_DATA_WIDTH-1:0] cfg_data,
  input  logic                      enable,
  output logic [DAC_WIDTH-1:0]      dac_dat,
  output logic                      dac_valid,
  output logic [1:0]                ramp_state,
  output logic                      ramp_done,
  output logic [DAC_WIDTH-1:0]      peak_min,
  output logic [DAC_WIDTH-1:0]      peak_max,
  output logic [15:0]               sat_count,
  input  logic                      peak_clear
);

  localparam int P1W = AXIS_TDATA_WIDTH + 1;
  localparam int M1W = AXIS_TDATA_WIDTH + 17;
  localparam int P2W = AXIS_TDATA_WIDTH + 2;
  localparam int M2W = P1W + ENV_W + 1;
  localparam int YW  = AXIS_TDATA_WIDTH + 3;
  localparam int SH  = AXIS_TDATA_WIDTH - DAC_WIDTH;

  localparam logic signed [YW-1:0] Y_MAX = YW'(DAC_MAX);
  localparam logic signed [YW-1:0] Y_MIN = YW'(DAC_MIN);

  logic [15:0]        amp;
  logic [15:0]        step;
  logic signed [15:0] offset;
  logic               accept;
  logic [ENV_W-1:0]   env;
  ramp_state_e        state;
  logic               unused_cfg;

  assign amp    = cfg_data[CFG_AMP_LSB +: 16];
  assign offset = cfg_data[CFG_OFF_LSB +: 16];
  assign step   = cfg_data[CFG_STEP_LSB +: 16];

  assign unused_cfg = ^cfg_data[CFG_DATA_WIDTH-1:48];

  assign s_axis.s_axis_tready = ~reset;
  assign accept = s_axis.s_axis_tvalid & s_axis.s_axis_tready;

  dac_ramp_envelope u_env (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .accept    (accept),
    .cfg_step  (step),
    .env       (env),
    .state     (state),
    .ramp_done (ramp_done)
  );

  assign ramp_state = state;

  logic                        v1_q, v1_d;
  logic                        v2_q, v2_d;
  logic                        v3_q, v3_d;
  logic                        dac_valid_q, dac_valid_d;
  logic signed [P1W-1:0]       p1_q, p1_d;
  logic [ENV_W-1:0]            env1_q, env1_d;
  logic signed [P2W-1:0]       p2_q, p2_d;
  logic signed [YW-1:0]        y_q, y_d;
  logic [DAC_WIDTH-1:0]        dac_dat_q, dac_dat_d;
  logic signed [M1W-1:0]       prod1;
  logic signed [M2W-1:0]       prod2;
  logic signed [DAC_WIDTH-1:0] word;
  logic                        sat;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      dac_valid_q <= 1'b0;
      p1_q        <= '0;
      env1_q      <= '0;
      p2_q        <= '0;
      y_q         <= '0;
      dac_dat_q   <= '0;
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      dac_valid_q <= dac_valid_d;
      p1_q        <= p1_d;
      env1_q      <= env1_d;
      p2_q        <= p2_d;
      y_q         <= y_d;
      dac_dat_q   <= dac_dat_d;
    end
  end

  // S1 scale, S2 envelope, S3 offset, then clamp into the output word.
  always_comb begin
    prod1 = M1W'($signed(s_axis.s_axis_tdata))
          * M1W'($signed({1'b0, amp}));
    p1_d   = P1W'(prod1 >>> 15);
    env1_d = env;
    v1_d   = accept;

    prod2 = M2W'(p1_q) * M2W'($signed({1'b0, env1_q}));
    p2_d  = P2W'(prod2 >>> 16);
    v2_d  = v1_q;

    y_d  = YW'(p2_q >>> SH) + YW'(offset);
    v3_d = v2_q;

    sat  = 1'b0;
    word = y_q[DAC_WIDTH-1:0];
    if (y_q > Y_MAX) begin
      word = DAC_WIDTH'(DAC_MAX);
      sat  = 1'b1;
    end else if (y_q < Y_MIN) begin
      word = DAC_WIDTH'(DAC_MIN);
      sat  = 1'b1;
    end
    dac_dat_d   = v3_q ? word : dac_dat_q;
    dac_valid_d = v3_q;
  end

  assign dac_dat   = dac_dat_q;
  assign dac_valid = dac_valid_q;

`ifdef PEAK_MONITOR_EN
  logic signed [DAC_WIDTH-1:0] peak_min_q, peak_min_d;
  logic signed [DAC_WIDTH-1:0] peak_max_q, peak_max_d;
  logic [15:0]                 sat_count_q, sat_count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      peak_min_q  <= '0;
      peak_max_q  <= '0;
      sat_count_q <= '0;
    end else begin
      peak_min_q  <= peak_min_d;
      peak_max_q  <= peak_max_d;
      sat_count_q <= sat_count_d;
    end
  end

  always_comb begin
    peak_min_d  = peak_min_q;
    peak_max_d  = peak_max_q;
    sat_count_d = sat_count_q;
    if (peak_clear) begin
      peak_min_d  = DAC_WIDTH'(DAC_MAX);
      peak_max_d  = DAC_WIDTH'(DAC_MIN);
      sat_count_d = '0;
    end else if (v3_q) begin
      if (word < peak_min_q) peak_min_d = word;
      if (word > peak_max_q) peak_max_d = word;
      if (sat && sat_count_q != 16'hFFFF)
        sat_count_d = sat_count_q + 16'd1;
    end
  end

  assign peak_min  = peak_min_q;
  assign peak_max  = peak_max_q;
  assign sat_count = sat_count_q;
`else
  logic unused_mon;
  assign unused_mon = ^{sat, peak_clear};
  assign peak_min   = '0;
  assign peak_max   = '0;
  assign sat_count  = '0;
`endif

endmodule
